// File: rtl/dmem_pkg.sv
// dmem_pkg: definitions shared by the data-memory responder files.
//   DATA_W / STRB_W : data word width and the matching byte-strobe width
//   TOHOST_ADDR     : byte address of the tohost register (DMEM_MMIO_EN builds)
//   state_t         : responder FSM states
package dmem_pkg;

    localparam int          DATA_W      = 32;
    localparam int          STRB_W      = DATA_W / 8;
    localparam logic [31:0] TOHOST_ADDR = 32'h0000_1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_if.sv
// dmem_if: load/store port between the CPU MEM stage (master) and the data
// memory (slave).
//   req_valid/req_ready : request handshake
//   req_wen             : 1 = write, 0 = read
//   req_addr            : byte address
//   req_wdata/req_wstrb : write data and byte-lane enables
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata/rsp_err   : read data and error flag
interface dmem_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_wen;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wstrb, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wstrb, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_array.sv
// dmem_array: single-port DEPTH x DATA_W word RAM.
//   clk   : clock
//   en    : access enable for this cycle
//   we    : 1 = write strobed bytes, 0 = read
//   wstrb : byte-lane write enables
//   idx   : word index
//   wdata : write data
//   rdata : registered read data, updated only by an enabled read
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [STRB_W-1:0] wstrb,
    input  logic [AW-1:0]     idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (wstrb[b]) begin
                        mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory behind a valid/ready load/store port.
// One request at a time; the response appears LATENCY cycles after acceptance
// and is held until the CPU takes it.
//   clk, reset : clock, synchronous active-high reset
//   bus        : dmem_if slave port (request/response handshakes)
//   halt, exit_code : tohost outputs, present only when DMEM_MMIO_EN is defined
// Optional feature macro: DMEM_MMIO_EN (tohost register at TOHOST_ADDR).
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    dmem_if.slave       bus
`ifdef DMEM_MMIO_EN
    ,
    output logic        halt,
    output logic [31:0] exit_code
`endif
);

    localparam int AW = $clog2(DEPTH);

    state_t            state;
    logic [3:0]        cnt;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic              rsp_from_arr;   // response data comes from the array read register
    logic [DATA_W-1:0] rsp_data_q;     // response data when not from the array

    // Latched request; data-only, not reset
    logic              l_wen;
    logic [31:0]       l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic [STRB_W-1:0] l_wstrb;

    logic              access;
    logic              addr_err;
    logic              is_tohost;
    logic              arr_en;
    logic [DATA_W-1:0] arr_rdata;

    // The access happens on the edge that leaves BUSY for RESP
    assign access   = (state == BUSY) && (cnt == 4'd0);
    assign addr_err = (l_addr[1:0] != 2'b00) || ((l_addr >> (AW + 2)) != 32'd0);

`ifdef DMEM_MMIO_EN
    assign is_tohost = (l_addr == TOHOST_ADDR);
`else
    assign is_tohost = 1'b0;
`endif

    assign arr_en = access && !is_tohost && !addr_err;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (l_wen),
        .wstrb (l_wstrb),
        .idx   (l_addr[AW+1:2]),
        .wdata (l_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if ((state == IDLE) && bus.req_valid) begin
            l_wen   <= bus.req_wen;
            l_addr  <= bus.req_addr;
            l_wdata <= bus.req_wdata;
            l_wstrb <= bus.req_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_from_arr <= 1'b0;
            rsp_data_q   <= '0;
`ifdef DMEM_MMIO_EN
            halt         <= 1'b0;
            exit_code    <= 32'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        cnt         <= 4'(LATENCY - 1);
                        req_ready_q <= 1'b0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state        <= RESP;
                        rsp_valid_q  <= 1'b1;
                        rsp_err_q    <= !is_tohost && addr_err;
                        rsp_from_arr <= !is_tohost && !addr_err && !l_wen;
                        rsp_data_q   <= '0;
`ifdef DMEM_MMIO_EN
                        if (is_tohost) begin
                            if (l_wen) begin
                                if (l_wstrb == 4'hF) begin
                                    halt      <= 1'b1;
                                    exit_code <= l_wdata;
                                end
                            end else begin
                                rsp_data_q <= exit_code;
                            end
                        end
`endif
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state        <= IDLE;
                        req_ready_q  <= 1'b1;
                        rsp_valid_q  <= 1'b0;
                        rsp_err_q    <= 1'b0;
                        rsp_from_arr <= 1'b0;
                        rsp_data_q   <= '0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    // Array read data is registered inside the array and only changes on an
    // enabled read, so it is stable for the whole RESP hold.
    assign bus.rsp_rdata = rsp_from_arr ? arr_rdata : rsp_data_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int DEPTH   = 1024;
    localparam int LATENCY = 3;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    dmem_if bus ();

`ifdef DMEM_MMIO_EN
    logic        halt;
    logic [31:0] exit_code;
`endif

    dmem_responder #(
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave)
`ifdef DMEM_MMIO_EN
        ,
        .halt      (halt),
        .exit_code (exit_code)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one transaction; returns response fields and cycles from accept to rsp_valid.
    task automatic xact(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] strb, output logic [31:0] rdata, output logic err,
                        output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.req_valid = 1'b1;
        bus.req_wen   = wen;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wstrb = strb;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready: got %b want 1", bus.req_ready);
        end
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_rsp: got valid=%b err=%b rdata=%h want 0/0/0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
`ifdef DMEM_MMIO_EN
        checks++;
        if (halt !== 1'b0 || exit_code !== 32'd0) begin
            errors++;
            $display("FAIL reset_mmio: got halt=%b exit=%h want 0/0", halt, exit_code);
        end
`endif
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        checks++;
        if (lat !== LATENCY) begin
            errors++;
            $display("FAIL basic_wr_latency: got %0d want %0d", lat, LATENCY);
        end
        checks++;
        if (rd !== 32'd0 || er !== 1'b0) begin
            errors++;
            $display("FAIL basic_wr_rsp: got rdata=%h err=%b want 0/0", rd, er);
        end
        xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (lat !== LATENCY) begin
            errors++;
            $display("FAIL basic_rd_latency: got %0d want %0d", lat, LATENCY);
        end
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            errors++;
            $display("FAIL basic_rd_data: got rdata=%h err=%b want deadbeef/0", rd, er);
        end
    endtask

    task automatic test_strobes();
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
        xact(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
        xact(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h11BB33DD || er !== 1'b0) begin
            errors++;
            $display("FAIL strobe_merge: got rdata=%h err=%b want 11bb33dd/0", rd, er);
        end
        // zero-strobe write is a no-op that still responds
        xact(1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, er, lat);
        checks++;
        if (lat !== LATENCY || er !== 1'b0) begin
            errors++;
            $display("FAIL strobe_zero_rsp: got lat=%0d err=%b want %0d/0", lat, er, LATENCY);
        end
        xact(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL strobe_zero_nowrite: got %h want 11bb33dd", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er;
        int          lat;
        xact(1'b0, 32'h22, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'd0 || er !== 1'b1) begin
            errors++;
            $display("FAIL err_misaligned: got rdata=%h err=%b want 0/1", rd, er);
        end
        xact(1'b1, 32'h1000_0000, 32'hCAFEF00D, 4'hF, rd, er, lat);
        checks++;
        if (rd !== 32'd0 || er !== 1'b1 || lat !== LATENCY) begin
            errors++;
            $display("FAIL err_range_wr: got rdata=%h err=%b lat=%0d want 0/1/%0d", rd, er, lat, LATENCY);
        end
        xact(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h11BB33DD || er !== 1'b0) begin
            errors++;
            $display("FAIL err_no_side_effect: got rdata=%h err=%b want 11bb33dd/0", rd, er);
        end
        // last word in range
        xact(1'b1, 32'hFFC, 32'h0BADF00D, 4'hF, rd, er, lat);
        xact(1'b0, 32'hFFC, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0BADF00D || er !== 1'b0) begin
            errors++;
            $display("FAIL err_last_word: got rdata=%h err=%b want 0badf00d/0", rd, er);
        end
`ifndef DMEM_MMIO_EN
        // first word past the end
        xact(1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'd0 || er !== 1'b1) begin
            errors++;
            $display("FAIL err_past_end: got rdata=%h err=%b want 0/1", rd, er);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          bad;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wen   = 1'b0;
        bus.req_addr  = 32'h10;
        bus.req_wstrb = 4'h0;
        bus.req_wdata = 32'h0;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 0;
        while (!bus.rsp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat !== LATENCY) begin
            errors++;
            $display("FAIL bp_latency: got %0d want %0d", lat, LATENCY);
        end
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) begin
                bus.req_valid = 1'b1;
                bus.req_wen   = 1'b1;
                bus.req_wdata = 32'h12121212;
                bus.req_wstrb = 4'hF;
            end else begin
                bus.req_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEADBEEF ||
                bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b0) bad++;
        end
        bus.req_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d unstable cycles, want 0", bad);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got valid=%b ready=%b want 0/1", bus.rsp_valid, bus.req_ready);
        end
        xact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bp_pulse_ignored: got %h want deadbeef", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          seen;
        xact(1'b1, 32'h30, 32'h12345678, 4'hF, rd, er, lat);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_wen   = 1'b1;
        bus.req_addr  = 32'h30;
        bus.req_wdata = 32'h00000055;
        bus.req_wstrb = 4'hF;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_state: got ready=%b valid=%b want 1/0", bus.req_ready, bus.rsp_valid);
        end
        seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.rsp_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rstmid_no_rsp: got %0d valid cycles want 0", seen);
        end
        xact(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h12345678) begin
            errors++;
            $display("FAIL rstmid_old_value: got %h want 12345678", rd);
        end
    endtask

`ifdef DMEM_MMIO_EN
    task automatic test_mmio();
        logic [31:0] rd;
        logic        er;
        int          lat;
        checks++;
        if (halt !== 1'b0) begin
            errors++;
            $display("FAIL mmio_pre_halt: got %b want 0", halt);
        end
        xact(1'b1, 32'h1000, 32'h00000001, 4'hF, rd, er, lat);
        checks++;
        if (halt !== 1'b1 || exit_code !== 32'd1 || er !== 1'b0) begin
            errors++;
            $display("FAIL mmio_halt: got halt=%b exit=%h err=%b want 1/1/0", halt, exit_code, er);
        end
        xact(1'b0, 32'h1000, 32'h0, 4'h0, rd, er, lat);
        checks++;
        if (rd !== 32'd1 || er !== 1'b0) begin
            errors++;
            $display("FAIL mmio_read: got rdata=%h err=%b want 1/0", rd, er);
        end
    endtask
`endif

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_wen   = 1'b0;
        bus.req_addr  = 32'd0;
        bus.req_wdata = 32'd0;
        bus.req_wstrb = 4'd0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_basic();
        test_strobes();
        test_errors();
        test_backpressure();
        test_reset_mid();
`ifdef DMEM_MMIO_EN
        test_mmio();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
